// File: rtl/cache_wbuf_pkg.sv
// Shared types and helpers for the cache store-path write buffer.
// Default geometry, the reference entry layout and word-address extraction.
package cache_wbuf_pkg;

    localparam int BUFFER_DEPTH_BITS = 2;
    localparam int WBUF_DEPTH_BITS   = BUFFER_DEPTH_BITS;
    localparam int WBUF_DEPTH        = 1 << WBUF_DEPTH_BITS;
    localparam int WBUF_ADDR_W       = 32;
    localparam int WBUF_DATA_W       = 32;
    localparam int WBUF_STRB_W       = WBUF_DATA_W / 8;
    localparam int WBUF_MODE_W       = 1;

    typedef struct packed {
        logic [WBUF_ADDR_W-1:0] addr;
        logic [WBUF_DATA_W-1:0] data;
        logic [WBUF_STRB_W-1:0] strb;
        logic [WBUF_MODE_W-1:0] mode;
    } wbuf_entry_t;

    function automatic logic [WBUF_ADDR_W-1:0] word_addr(
        input logic [WBUF_ADDR_W-1:0] addr,
        input int unsigned            offs
    );
        return addr >> offs;
    endfunction

endpackage

// File: rtl/cache_wbuf_if.sv
// Store-side, memory-side, lookup and status signals of the write buffer.
// Signal names are given from the buffer's point of view.
interface cache_wbuf_if #(
    parameter int DEPTH_BITS = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    localparam int DATA_BYTES = DATA_WIDTH / 8;

    logic                  wr_valid_i;
    logic                  wr_ready_o;
    logic [ADDR_WIDTH-1:0] wr_addr_i;
    logic [DATA_WIDTH-1:0] wr_data_i;
    logic [DATA_BYTES-1:0] wr_strb_i;
    logic                  wr_mode_i;
    logic                  mem_valid_o;
    logic                  mem_ready_i;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_data_o;
    logic [DATA_BYTES-1:0] mem_strb_o;
    logic                  mem_mode_o;
    logic [ADDR_WIDTH-1:0] lk_addr_i;
    logic                  lk_hit_o;
    logic                  lk_full_o;
    logic [DATA_WIDTH-1:0] lk_data_o;
    logic [DATA_BYTES-1:0] lk_strb_o;
    logic                  drain_i;
    logic [DEPTH_BITS:0]   count_o;
    logic                  empty_o;

    modport slave (
        input  wr_valid_i, wr_addr_i, wr_data_i, wr_strb_i, wr_mode_i,
        output wr_ready_o,
        output mem_valid_o, mem_addr_o, mem_data_o, mem_strb_o, mem_mode_o,
        input  mem_ready_i,
        input  lk_addr_i,
        output lk_hit_o, lk_full_o, lk_data_o, lk_strb_o,
        input  drain_i,
        output count_o, empty_o
    );

    modport master (
        output wr_valid_i, wr_addr_i, wr_data_i, wr_strb_i, wr_mode_i,
        input  wr_ready_o,
        input  mem_valid_o, mem_addr_o, mem_data_o, mem_strb_o, mem_mode_o,
        output mem_ready_i,
        output lk_addr_i,
        input  lk_hit_o, lk_full_o, lk_data_o, lk_strb_o,
        output drain_i,
        input  count_o, empty_o
    );
endinterface

// File: rtl/cache_wbuf_fwd.sv
// Store-to-load forwarding: walks entries oldest to youngest from the read
// pointer so the youngest matching writer of each byte wins.
module cache_wbuf_fwd
    import cache_wbuf_pkg::*;
#(
    parameter int DEPTH_BITS = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic [(1<<DEPTH_BITS)-1:0]                     valid_i,
    input  logic [(1<<DEPTH_BITS)-1:0][ADDR_WIDTH-1:0]     addr_i,
    input  logic [(1<<DEPTH_BITS)-1:0][DATA_WIDTH-1:0]     data_i,
    input  logic [(1<<DEPTH_BITS)-1:0][DATA_WIDTH/8-1:0]   strb_i,
    input  logic [DEPTH_BITS-1:0]                          rd_idx_i,
    input  logic [ADDR_WIDTH-1:0]                          lk_addr_i,
    output logic                                           hit_o,
    output logic                                           full_o,
    output logic [DATA_WIDTH-1:0]                          data_o,
    output logic [DATA_WIDTH/8-1:0]                        strb_o
);
    localparam int DEPTH      = 1 << DEPTH_BITS;
    localparam int DATA_BYTES = DATA_WIDTH / 8;
    localparam int OFFS       = $clog2(DATA_BYTES);

    logic [DEPTH_BITS-1:0] idx_s;
    logic                  match_s;
    logic                  take_s;
    logic [DATA_WIDTH-1:0] data_s;
    logic [DATA_BYTES-1:0] strb_s;

    // Age-ordered priority merge; later (younger) entries overwrite earlier ones.
    always_comb begin
        idx_s   = '0;
        match_s = 1'b0;
        take_s  = 1'b0;
        data_s  = '0;
        strb_s  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx_s   = rd_idx_i + DEPTH_BITS'(k);
            match_s = valid_i[idx_s] &&
                      (word_addr(WBUF_ADDR_W'(addr_i[idx_s]), OFFS) ==
                       word_addr(WBUF_ADDR_W'(lk_addr_i), OFFS));
            for (int b = 0; b < DATA_BYTES; b++) begin
                take_s           = match_s & strb_i[idx_s][b];
                data_s[b*8 +: 8] = take_s ? data_i[idx_s][b*8 +: 8] : data_s[b*8 +: 8];
                strb_s[b]        = strb_s[b] | take_s;
            end
        end
    end

    assign data_o = data_s;
    assign strb_o = strb_s;
    assign hit_o  = |strb_s;
    assign full_o = &strb_s;

endmodule

// File: rtl/cache_wbuf.sv
// Circular write buffer between the cache store path and the memory bus,
// with same-word coalescing into the youngest entry and forwarding lookup.
module cache_wbuf
    import cache_wbuf_pkg::*;
#(
    parameter int DEPTH_BITS = WBUF_DEPTH_BITS,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int COALESCE   = 1,
    parameter int FORWARD    = 1
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    cache_wbuf_if.slave  bus
);
    localparam int DEPTH      = 1 << DEPTH_BITS;
    localparam int DATA_BYTES = DATA_WIDTH / 8;
    localparam int OFFS       = $clog2(DATA_BYTES);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic [DATA_BYTES-1:0] strb;
        logic                  mode;
    } entry_t;

    entry_t                ent_q [DEPTH];
    logic [DEPTH-1:0]      valid_q;
    logic [DEPTH_BITS:0]   wr_ptr_q, rd_ptr_q;

    logic [DEPTH_BITS-1:0] wr_idx_s, rd_idx_s, young_idx_s, slot_s;
    logic [DEPTH_BITS:0]   count_s;
    logic                  full_s, empty_s, merge_ok_s, push_s, merge_s, new_s, pop_s;
    entry_t                young_s, ent_d;

    assign wr_idx_s    = wr_ptr_q[DEPTH_BITS-1:0];
    assign rd_idx_s    = rd_ptr_q[DEPTH_BITS-1:0];
    assign young_idx_s = wr_idx_s - DEPTH_BITS'(1);
    assign young_s     = ent_q[young_idx_s];
    assign count_s     = wr_ptr_q - rd_ptr_q;
    assign empty_s     = (wr_ptr_q == rd_ptr_q);
    assign full_s      = (wr_idx_s == rd_idx_s) && (wr_ptr_q[DEPTH_BITS] != rd_ptr_q[DEPTH_BITS]);

    // The count >= 2 term keeps the head entry immutable while it is offered.
    assign merge_ok_s = (COALESCE == 1) && !bus.wr_mode_i && !young_s.mode &&
                        (count_s >= (DEPTH_BITS+1)'(2)) &&
                        (word_addr(WBUF_ADDR_W'(young_s.addr), OFFS) ==
                         word_addr(WBUF_ADDR_W'(bus.wr_addr_i), OFFS));

    assign bus.wr_ready_o = !bus.drain_i && (!full_s || merge_ok_s);
    assign push_s  = bus.wr_valid_i && bus.wr_ready_o;
    assign merge_s = push_s && merge_ok_s;
    assign new_s   = push_s && !merge_ok_s;
    assign pop_s   = !empty_s && bus.mem_ready_i;
    assign slot_s  = merge_s ? young_idx_s : wr_idx_s;

    // Build the entry to write: a fresh store, or the youngest entry with new bytes laid over it.
    always_comb begin
        ent_d      = '0;
        ent_d.addr = merge_s ? young_s.addr : bus.wr_addr_i;
        ent_d.mode = merge_s ? young_s.mode : bus.wr_mode_i;
        ent_d.strb = merge_s ? (young_s.strb | bus.wr_strb_i) : bus.wr_strb_i;
        for (int b = 0; b < DATA_BYTES; b++) begin
            ent_d.data[b*8 +: 8] = (merge_s && !bus.wr_strb_i[b]) ? young_s.data[b*8 +: 8]
                                                                  : bus.wr_data_i[b*8 +: 8];
        end
    end

    // Pointer, valid-bit and entry storage update.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            valid_q  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                ent_q[k] <= '0;
            end
        end else begin
            if (pop_s) begin
                rd_ptr_q          <= rd_ptr_q + (DEPTH_BITS+1)'(1);
                valid_q[rd_idx_s] <= 1'b0;
            end
            if (new_s) begin
                wr_ptr_q          <= wr_ptr_q + (DEPTH_BITS+1)'(1);
                valid_q[wr_idx_s] <= 1'b1;
            end
            if (push_s) begin
                ent_q[slot_s] <= ent_d;
            end
        end
    end

    assign bus.mem_valid_o = !empty_s;
    assign bus.mem_addr_o  = ent_q[rd_idx_s].addr;
    assign bus.mem_data_o  = ent_q[rd_idx_s].data;
    assign bus.mem_strb_o  = ent_q[rd_idx_s].strb;
    assign bus.mem_mode_o  = ent_q[rd_idx_s].mode;
    assign bus.count_o     = count_s;
    assign bus.empty_o     = empty_s;

    generate
        if (FORWARD == 1) begin : g_fwd
            logic [DEPTH-1:0][ADDR_WIDTH-1:0] addr_f;
            logic [DEPTH-1:0][DATA_WIDTH-1:0] data_f;
            logic [DEPTH-1:0][DATA_BYTES-1:0] strb_f;

            // Flatten entry storage for the forwarding network.
            always_comb begin
                addr_f = '0;
                data_f = '0;
                strb_f = '0;
                for (int k = 0; k < DEPTH; k++) begin
                    addr_f[k] = ent_q[k].addr;
                    data_f[k] = ent_q[k].data;
                    strb_f[k] = ent_q[k].strb;
                end
            end

            cache_wbuf_fwd #(
                .DEPTH_BITS (DEPTH_BITS),
                .DATA_WIDTH (DATA_WIDTH),
                .ADDR_WIDTH (ADDR_WIDTH)
            ) u_fwd (
                .valid_i   (valid_q),
                .addr_i    (addr_f),
                .data_i    (data_f),
                .strb_i    (strb_f),
                .rd_idx_i  (rd_idx_s),
                .lk_addr_i (bus.lk_addr_i),
                .hit_o     (bus.lk_hit_o),
                .full_o    (bus.lk_full_o),
                .data_o    (bus.lk_data_o),
                .strb_o    (bus.lk_strb_o)
            );
        end else begin : g_nofwd
            assign bus.lk_hit_o  = 1'b0;
            assign bus.lk_full_o = 1'b0;
            assign bus.lk_data_o = '0;
            assign bus.lk_strb_o = '0;
        end
    endgenerate

endmodule

// File: tb/tb_cache_wbuf.sv
// Directed bench for cache_wbuf: stimulus queues expected memory-side beats,
// a negedge monitor compares every accepted head against that queue.
module tb_cache_wbuf;
    import cache_wbuf_pkg::*;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   n_tests = 0;
    int   n_failed = 0;
    wbuf_entry_t exp_q[$];

    always #5 clk = ~clk;

    cache_wbuf_if #(.DEPTH_BITS(2), .DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    cache_wbuf #(
        .DEPTH_BITS (2),
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .COALESCE   (1),
        .FORWARD    (1)
    ) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus.slave)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic wbuf_entry_t mk(input logic [31:0] a, input logic [31:0] d,
                                       input logic [3:0] s, input logic m);
        wbuf_entry_t e;
        e.addr = a; e.data = d; e.strb = s; e.mode = m;
        return e;
    endfunction

    // Memory-side monitor: every accepted head beat must match the next expected entry.
    initial begin
        wbuf_entry_t e;
        forever begin
            @(negedge clk);
            if (rstn && bus.mem_valid_o && bus.mem_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_failed++;
                    $display("FAIL pop_unexpected: got addr %0h expected no beat", bus.mem_addr_o);
                end else begin
                    e = exp_q.pop_front();
                    check("mem_addr", 64'(bus.mem_addr_o), 64'(e.addr));
                    check("mem_data", 64'(bus.mem_data_o), 64'(e.data));
                    check("mem_strb", 64'(bus.mem_strb_o), 64'(e.strb));
                    check("mem_mode", 64'(bus.mem_mode_o), 64'(e.mode));
                end
            end
        end
    end

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic m);
        int waited = 0;
        bus.wr_valid_i = 1'b1;
        bus.wr_addr_i  = a;
        bus.wr_data_i  = d;
        bus.wr_strb_i  = s;
        bus.wr_mode_i  = m;
        @(negedge clk);
        while (!bus.wr_ready_o && waited < 40) begin
            waited++;
            @(negedge clk);
        end
        if (!bus.wr_ready_o) check("push_timeout", 64'(waited), 64'(0));
        @(posedge clk);
        #1;
        bus.wr_valid_i = 1'b0;
    endtask

    task automatic drain_all();
        int waited = 0;
        bus.mem_ready_i = 1'b1;
        @(negedge clk);
        while (!bus.empty_o && waited < 40) begin
            waited++;
            @(negedge clk);
        end
        check("drain_empty", 64'(bus.empty_o), 64'(1));
        bus.mem_ready_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input string name, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
        bus.lk_addr_i = a;
        #1;
        check({name, "_data"}, 64'(bus.lk_data_o), 64'(d));
        check({name, "_strb"}, 64'(bus.lk_strb_o), 64'(s));
        check({name, "_hit"},  64'(bus.lk_hit_o),  64'(s != 4'h0));
        check({name, "_full"}, 64'(bus.lk_full_o), 64'(s == 4'hF));
    endtask

    initial begin
        bus.wr_valid_i  = 1'b0;
        bus.wr_addr_i   = '0;
        bus.wr_data_i   = '0;
        bus.wr_strb_i   = '0;
        bus.wr_mode_i   = 1'b0;
        bus.mem_ready_i = 1'b0;
        bus.lk_addr_i   = '0;
        bus.drain_i     = 1'b0;
        repeat (2) @(posedge clk);
        #2 rstn = 1'b1;
        @(posedge clk);
        #1;

        // 1: reset state, then a single store visible on mem and lookup
        check("rst_empty", 64'(bus.empty_o), 64'(1));
        check("rst_count", 64'(bus.count_o), 64'(0));
        check("rst_mem_valid", 64'(bus.mem_valid_o), 64'(0));
        check("rst_wr_ready", 64'(bus.wr_ready_o), 64'(1));
        check("rst_lk_hit", 64'(bus.lk_hit_o), 64'(0));
        check("rst_lk_strb", 64'(bus.lk_strb_o), 64'(0));
        push(32'h100, 32'hAABBCCDD, 4'hF, 1'b0);
        exp_q.push_back(mk(32'h100, 32'hAABBCCDD, 4'hF, 1'b0));
        check("t1_mem_valid", 64'(bus.mem_valid_o), 64'(1));
        check("t1_count", 64'(bus.count_o), 64'(1));
        check("t1_mem_addr", 64'(bus.mem_addr_o), 64'(32'h100));
        lookup("t1_lk", 32'h102, 32'hAABBCCDD, 4'hF);
        drain_all();

        // 2: coalesce into the youngest (non-head) entry
        push(32'h200, 32'h11, 4'h1, 1'b0);
        push(32'h300, 32'h22, 4'h1, 1'b0);
        push(32'h301, 32'h3300, 4'h2, 1'b0);
        exp_q.push_back(mk(32'h200, 32'h11, 4'h1, 1'b0));
        exp_q.push_back(mk(32'h300, 32'h3322, 4'h3, 1'b0));
        check("t2_count", 64'(bus.count_o), 64'(2));
        lookup("t2_lk", 32'h300, 32'h3322, 4'h3);
        drain_all();

        // 3: head never merged, uncached never merged
        push(32'h400, 32'hA1, 4'h1, 1'b0);
        push(32'h400, 32'hB200, 4'h2, 1'b0);
        check("t3_count_head", 64'(bus.count_o), 64'(2));
        push(32'h500, 32'h5, 4'h1, 1'b1);
        push(32'h500, 32'h600, 4'h2, 1'b0);
        check("t3_count_mode", 64'(bus.count_o), 64'(4));
        lookup("t3_lk", 32'h400, 32'hB2A1, 4'h3);
        exp_q.push_back(mk(32'h400, 32'hA1, 4'h1, 1'b0));
        exp_q.push_back(mk(32'h400, 32'hB200, 4'h2, 1'b0));
        exp_q.push_back(mk(32'h500, 32'h5, 4'h1, 1'b1));
        exp_q.push_back(mk(32'h500, 32'h600, 4'h2, 1'b0));
        drain_all();

        // 4: full buffer, merge while full, full+pop rejects, in-order drain across wrap
        push(32'h700, 32'hA0A0A0A0, 4'hF, 1'b0);
        push(32'h704, 32'hA1A1A1A1, 4'hF, 1'b0);
        push(32'h708, 32'hA2A2A2A2, 4'hF, 1'b0);
        push(32'h70C, 32'hA3A3A3A3, 4'hF, 1'b0);
        bus.wr_addr_i = 32'h800;
        #1;
        check("t4_full_ready", 64'(bus.wr_ready_o), 64'(0));
        check("t4_full_count", 64'(bus.count_o), 64'(4));
        bus.wr_addr_i = 32'h70E;
        bus.wr_mode_i = 1'b0;
        #1;
        check("t4_merge_ready", 64'(bus.wr_ready_o), 64'(1));
        push(32'h70E, 32'h00990000, 4'h4, 1'b0);
        check("t4_merge_count", 64'(bus.count_o), 64'(4));
        exp_q.push_back(mk(32'h700, 32'hA0A0A0A0, 4'hF, 1'b0));
        exp_q.push_back(mk(32'h704, 32'hA1A1A1A1, 4'hF, 1'b0));
        exp_q.push_back(mk(32'h708, 32'hA2A2A2A2, 4'hF, 1'b0));
        exp_q.push_back(mk(32'h70C, 32'hA399A3A3, 4'hF, 1'b0));
        bus.wr_valid_i  = 1'b1;
        bus.wr_addr_i   = 32'h800;
        bus.wr_data_i   = 32'hDEAD;
        bus.wr_strb_i   = 4'hF;
        bus.wr_mode_i   = 1'b1;
        bus.mem_ready_i = 1'b1;
        @(negedge clk);
        check("t4_full_pop_ready", 64'(bus.wr_ready_o), 64'(0));
        @(posedge clk);
        #1;
        bus.wr_valid_i = 1'b0;
        check("t4_after_pop_count", 64'(bus.count_o), 64'(3));
        drain_all();

        // 5: forwarding priority, youngest writer wins per byte, regardless of mode
        push(32'h600, 32'h11111111, 4'hF, 1'b0);
        push(32'h600, 32'h2222, 4'h3, 1'b1);
        check("t5_count", 64'(bus.count_o), 64'(2));
        lookup("t5_lk", 32'h600, 32'h11112222, 4'hF);
        lookup("t5_miss", 32'h604, 32'h0, 4'h0);
        exp_q.push_back(mk(32'h600, 32'h11111111, 4'hF, 1'b0));
        exp_q.push_back(mk(32'h600, 32'h2222, 4'h3, 1'b1));
        drain_all();

        // 6: drain blocks stores until empty, then async reset mid-pop
        push(32'h900, 32'h9, 4'hF, 1'b0);
        push(32'h904, 32'h99, 4'hF, 1'b0);
        push(32'h908, 32'h999, 4'hF, 1'b0);
        exp_q.push_back(mk(32'h900, 32'h9, 4'hF, 1'b0));
        exp_q.push_back(mk(32'h904, 32'h99, 4'hF, 1'b0));
        exp_q.push_back(mk(32'h908, 32'h999, 4'hF, 1'b0));
        bus.drain_i = 1'b1;
        #1;
        check("t6_drain_ready", 64'(bus.wr_ready_o), 64'(0));
        drain_all();
        check("t6_drain_count", 64'(bus.count_o), 64'(0));
        bus.drain_i = 1'b0;
        push(32'hA00, 32'hA, 4'hF, 1'b0);
        push(32'hA04, 32'hAA, 4'hF, 1'b0);
        check("t6_pre_rst_count", 64'(bus.count_o), 64'(2));
        bus.mem_ready_i = 1'b1;
        #1 rstn = 1'b0;
        #1;
        check("t6_rst_count", 64'(bus.count_o), 64'(0));
        check("t6_rst_mem_valid", 64'(bus.mem_valid_o), 64'(0));
        check("t6_rst_empty", 64'(bus.empty_o), 64'(1));
        @(negedge clk);
        rstn = 1'b1;
        bus.mem_ready_i = 1'b0;
        @(posedge clk);
        #1;
        check("t6_post_rst_count", 64'(bus.count_o), 64'(0));
        lookup("t6_lk", 32'hA00, 32'h0, 4'h0);

        check("exp_q_empty", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cache_wbuf.md
Name: cache_wbuf

Overview:
- Parametrised write buffer between the cache store path and the memory-side bus.
- Queues stores as {addr, data, strb, mode} entries in a circular buffer of 2**DEPTH_BITS entries.
- Merges back-to-back cacheable stores to the same word into one entry.
- Offers a combinational store-to-load forwarding lookup so the cache can read pending bytes before they drain.

Parameters:
- DEPTH_BITS, 2, log2 of entry count (DEPTH = 2**DEPTH_BITS).
- DATA_WIDTH, 32, store data width; DATA_BYTES = DATA_WIDTH/8.
- ADDR_WIDTH, 32, byte address width.
- COALESCE, 1, 1 enables same-word merge into the youngest entry.
- FORWARD, 1, 1 enables the lookup port; 0 ties lk_* outputs to 0.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  asynchronous active-low reset.
- wr_valid_i  in  1  store request valid.
- wr_ready_o  out  1  buffer can accept or merge the store.
- wr_addr_i  in  ADDR_WIDTH  store byte address.
- wr_data_i  in  DATA_WIDTH  store data.
- wr_strb_i  in  DATA_BYTES  byte enables.
- wr_mode_i  in  1  1 = uncached/ordered store, never merged.
- mem_valid_o  out  1  head entry valid.
- mem_ready_i  in  1  memory side accepts head.
- mem_addr_o  out  ADDR_WIDTH  head address.
- mem_data_o  out  DATA_WIDTH  head data.
- mem_strb_o  out  DATA_BYTES  head strobes.
- mem_mode_o  out  1  head mode.
- lk_addr_i  in  ADDR_WIDTH  forwarding lookup address.
- lk_hit_o  out  1  at least one pending byte for the lk word.
- lk_full_o  out  1  all DATA_BYTES bytes are covered.
- lk_data_o  out  DATA_WIDTH  forwarded bytes; youngest writer wins per byte.
- lk_strb_o  out  DATA_BYTES  bytes valid in lk_data_o.
- drain_i  in  1  block new stores until the buffer is empty.
- count_o  out  DEPTH_BITS+1  occupied entries.
- empty_o  out  1  count_o == 0.

Behaviour:
- Reset (async, rstn_i low):
  - rd/wr pointers 0, all entry valid bits 0, count_o 0.
  - empty_o 1, mem_valid_o 0, wr_ready_o 1.
  - lk_hit_o, lk_full_o, lk_strb_o 0; mem_*/lk_data_o are don't-care but driven 0.
- Pointers:
  - DEPTH_BITS+1 bits with a wrap bit.
  - full when indices are equal and wrap bits differ; empty when the pointers are equal.
- Push: fires when wr_valid_i & wr_ready_o. The entry is written at the rising edge; it is visible on mem_* / lk_* from the next cycle (1-cycle latency).
- Merge condition (all must hold):
  - COALESCE = 1, and wr_mode_i = 0;
  - the youngest entry has mode 0;
  - the youngest entry's word address (addr[ADDR_WIDTH-1:log2 DATA_BYTES]) equals the incoming word address;
  - count_o >= 2, so the head is never merged into and mem_* stays stable while mem_valid_o is high.
- Merge effect:
  - bytes with wr_strb_i set overwrite the stored bytes; strb becomes old | new;
  - address and mode unchanged; wr_ptr and count unchanged.
- wr_ready_o = !drain_i & (!full | merge_possible).
  - Independent of mem_ready_i; no comb path from memory side to store side.
  - A full buffer with a simultaneous pop still rejects a non-merging push that cycle.
- Pop:
  - mem_valid_o = !empty; head presented from storage at rd_ptr.
  - On mem_valid_o & mem_ready_i: rd_ptr increments and the entry valid bit clears.
- Simultaneous push + pop: count unchanged for a new entry; count-1 for a merge.
- Zero-strobe store (wr_strb_i = 0): accepted and enqueued as given, or merged as a no-op.
- Forwarding: purely combinational over all valid entries.
  - Match on word address regardless of mode.
  - Per byte, the youngest matching entry with that strb bit set supplies the data.
  - lk_strb_o = OR of the contributing strobes; lk_hit_o = |lk_strb_o; lk_full_o = &lk_strb_o.
  - An entry being pushed this cycle is not visible; an entry being popped this cycle is still visible.
- Drain: while drain_i = 1, no pushes are accepted and pops continue; software/FSM waits on empty_o.
- Reset mid-operation: all pending entries are discarded immediately; no mem handshake completes.

Decomposition:
- cache_pkg additions:
  - WBUF_DEPTH_BITS (reuse BUFFER_DEPTH_BITS) and WBUF_DEPTH;
  - typedef wbuf_entry_t packed {addr, data, strb, mode} using the existing ADDR/DATA/STRB/MODE field widths;
  - function word_addr().
- Sub-module cache_wbuf_fwd: per-byte youngest-match priority merge over DEPTH entries, given rd_ptr for age ordering.

Test Plan:
1. Reset, then push addr 0x100 data 0xAABBCCDD strb 0xF mode 0 with mem_ready_i = 0:
   - next cycle mem_valid_o = 1, mem_addr_o = 0x100, count_o = 1;
   - lk_addr 0x102 gives lk_full_o = 1, lk_data_o = 0xAABBCCDD.
2. Coalesce: push 0x200/strb 0x1/data 0x11, then 0x300/strb 0x1/data 0x22, then 0x301/strb 0x2/data 0x3300:
   - count_o = 2;
   - second entry strb 0x3, data 0x3322.
3. Head protection and mode: push 0x400/strb 0x1 into an empty buffer, then 0x400/strb 0x2:
   - two entries, because the head is never merged.
   - Push 0x500 with mode 1 followed by 0x500: never merged.
4. Full: with DEPTH = 4, push 4 distinct words and mem_ready_i = 0:
   - wr_ready_o = 0;
   - a same-word store to the youngest entry keeps wr_ready_o = 1 and merges;
   - raising mem_ready_i pops one entry in order 0,1,2,3 with pointer wrap.
5. Forwarding priority: entries 0x600/strb 0xF/0x11111111 (older) and 0x600/strb 0x3/0x2222 (mode 1):
   - lk_addr 0x600 gives lk_data_o = 0x11112222, lk_strb_o = 0xF.
6. Drain and reset: assert drain_i with 3 entries queued:
   - wr_ready_o = 0 and empty_o rises after 3 pops.
   - Async rstn_i low mid-pop clears count_o and mem_valid_o immediately.
